// File: rtl/spi_mem_pkg.sv
// Shared types and constants for the SPI memory responder.
package spi_mem_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        ADDR,
        READ,
        WRITE,
        IGNORE
    } state_e;

    localparam logic [7:0] DEF_CMD_READ  = 8'h03;
    localparam logic [7:0] DEF_CMD_WRITE = 8'h02;

    localparam int CMD_BITS  = 8;
    localparam int ADDR_BITS = 24;

    function automatic logic [3:0] lane_mask(input logic [1:0] lane);
        return 4'b0001 << lane;
    endfunction

endpackage

// File: rtl/spi_mem_array.sv
// Word array with byte-lane SPI write, asynchronous read and a priority preload port.
module spi_mem_array #(
    parameter int DEPTH_WORDS = 1024,
    parameter int AW          = $clog2(DEPTH_WORDS)
) (
    input  logic          clk,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [3:0]    wr_be,
    input  logic [31:0]   wr_data,
    input  logic          ld_en,
    input  logic [AW-1:0] ld_addr,
    input  logic [31:0]   ld_data,
    input  logic [AW-1:0] rd_addr,
    output logic [31:0]   rd_data
);

    logic [31:0] mem_q [DEPTH_WORDS];
    logic        spi_wr_ok;

    // A preload to the same word owns the whole word, not just the other lanes.
    assign spi_wr_ok = wr_en && !(ld_en && (ld_addr == wr_addr));

    // NOTE: the array has no reset on purpose; contents must survive rstn.
    always_ff @(posedge clk) begin
        if (ld_en) begin
            mem_q[ld_addr] <= ld_data;
        end
        if (spi_wr_ok) begin
            for (int b = 0; b < 4; b++) begin
                if (wr_be[b]) begin
                    mem_q[wr_addr][8*b +: 8] <= wr_data[8*b +: 8];
                end
            end
        end
    end

    assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/spi_mem_responder.sv
// Device end of the nanoV SPI memory link: command/address decode, LSB-first
// byte streaming for reads and byte collection for writes.
module spi_mem_responder
    import spi_mem_pkg::*;
#(
    parameter int         DEPTH_WORDS = 1024,
    parameter int         AW          = $clog2(DEPTH_WORDS),
    parameter logic [7:0] CMD_READ    = DEF_CMD_READ,
    parameter logic [7:0] CMD_WRITE   = DEF_CMD_WRITE
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          spi_select,
    input  logic          spi_mosi,
    output logic          spi_miso,
    input  logic          ld_en,
    input  logic [AW-1:0] ld_addr,
    input  logic [31:0]   ld_data,
    output logic          busy
);

    localparam int         BW        = AW + 2;
    localparam logic [4:0] CMD_LAST  = 5'(CMD_BITS - 1);
    localparam logic [4:0] ADDR_LAST = 5'(ADDR_BITS - 1);

    state_e                 state_q, state_d;
    logic [4:0]             bit_cnt_q, bit_cnt_d;
    logic [CMD_BITS-1:0]    cmd_q, cmd_d;
    logic [ADDR_BITS-1:0]   addr_q, addr_d;
    logic [6:0]             wr_bits_q, wr_bits_d;
    logic                   miso_q, miso_d;

    logic [ADDR_BITS-1:0]   addr_shift;
    logic [BW-1:0]          addr_inc;
    logic [ADDR_BITS-1:0]   addr_next;
    logic                   byte_done;
    logic [7:0]             wr_byte_full;
    logic [BW-1:0]          rd_byte_addr;
    logic [2:0]             rd_bit_sel;
    logic [31:0]            rd_word;
    logic                   rd_bit;
    logic                   wr_en;

    assign addr_shift   = {addr_q[ADDR_BITS-2:0], spi_mosi};
    // Only the bits that index the array take part in the increment, so the
    // byte address wraps from the last byte back to zero.
    assign addr_inc     = addr_q[BW-1:0] + BW'(1);
    assign addr_next    = {{(ADDR_BITS-BW){1'b0}}, addr_inc};
    assign byte_done    = (bit_cnt_q[2:0] == 3'd7);
    assign wr_byte_full = {spi_mosi, wr_bits_q};

    // Byte and bit that will be on spi_miso after this edge.
    always_comb begin
        if (state_q == ADDR) begin
            rd_byte_addr = addr_shift[BW-1:0];
            rd_bit_sel   = 3'd0;
        end else if (byte_done) begin
            rd_byte_addr = addr_inc;
            rd_bit_sel   = 3'd0;
        end else begin
            rd_byte_addr = addr_q[BW-1:0];
            rd_bit_sel   = bit_cnt_q[2:0] + 3'd1;
        end
    end

    assign rd_bit = rd_word[{rd_byte_addr[1:0], rd_bit_sel}];

    // NOTE: every output gets a default first so no path can infer a latch.
    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        cmd_d     = cmd_q;
        addr_d    = addr_q;
        wr_bits_d = wr_bits_q;
        miso_d    = 1'b0;
        wr_en     = 1'b0;

        if (spi_select) begin
            state_d   = IDLE;
            bit_cnt_d = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    cmd_d     = {{(CMD_BITS-1){1'b0}}, spi_mosi};
                    bit_cnt_d = 5'd1;
                    state_d   = CMD;
                end
                CMD: begin
                    cmd_d = {cmd_q[CMD_BITS-2:0], spi_mosi};
                    if (bit_cnt_q == CMD_LAST) begin
                        bit_cnt_d = '0;
                        state_d   = (cmd_d == CMD_READ || cmd_d == CMD_WRITE) ? ADDR : IGNORE;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 5'd1;
                    end
                end
                ADDR: begin
                    addr_d = addr_shift;
                    if (bit_cnt_q == ADDR_LAST) begin
                        bit_cnt_d = '0;
                        if (cmd_q == CMD_READ) begin
                            state_d = READ;
                            miso_d  = rd_bit;
                        end else begin
                            state_d = WRITE;
                        end
                    end else begin
                        bit_cnt_d = bit_cnt_q + 5'd1;
                    end
                end
                READ: begin
                    miso_d = rd_bit;
                    if (byte_done) begin
                        bit_cnt_d = '0;
                        addr_d    = addr_next;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 5'd1;
                    end
                end
                WRITE: begin
                    wr_bits_d = {spi_mosi, wr_bits_q[6:1]};
                    if (byte_done) begin
                        wr_en     = 1'b1;
                        bit_cnt_d = '0;
                        addr_d    = addr_next;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 5'd1;
                    end
                end
                IGNORE: begin
                    state_d = IGNORE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= IDLE;
            bit_cnt_q <= '0;
            cmd_q     <= '0;
            addr_q    <= '0;
            wr_bits_q <= '0;
            miso_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            cmd_q     <= cmd_d;
            addr_q    <= addr_d;
            wr_bits_q <= wr_bits_d;
            miso_q    <= miso_d;
        end
    end

    spi_mem_array #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .AW          (AW)
    ) u_array (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_addr (addr_q[BW-1:2]),
        .wr_be   (lane_mask(addr_q[1:0])),
        .wr_data ({4{wr_byte_full}}),
        .ld_en   (ld_en),
        .ld_addr (ld_addr),
        .ld_data (ld_data),
        .rd_addr (rd_byte_addr[BW-1:2]),
        .rd_data (rd_word)
    );

    assign spi_miso = miso_q;
    assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_spi_mem_responder.sv
// Self-checking bench for spi_mem_responder: hand-computed read vectors,
// corner-case sequences and random traffic against a byte-array model.
module tb_spi_mem_responder;

    localparam int DEPTH = 1024;
    localparam int AW    = 10;
    localparam int NB    = DEPTH * 4;

    logic          clk;
    logic          rstn;
    logic          spi_select;
    logic          spi_mosi;
    logic          spi_miso;
    logic          ld_en;
    logic [AW-1:0] ld_addr;
    logic [31:0]   ld_data;
    logic          busy;

    int total = 0;
    int bad   = 0;

    logic [7:0] mb [NB];

    typedef struct {
        logic [23:0] addr;
        logic [31:0] exp;
    } rd_vec_t;

    rd_vec_t vecs [6];

    spi_mem_responder dut (
        .clk        (clk),
        .rstn       (rstn),
        .spi_select (spi_select),
        .spi_mosi   (spi_mosi),
        .spi_miso   (spi_miso),
        .ld_en      (ld_en),
        .ld_addr    (ld_addr),
        .ld_data    (ld_data),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation still running at %0t, limit 3000000", $time);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] model_word(input int byte_addr);
        logic [31:0] w;
        for (int k = 0; k < 4; k++) w[8*k +: 8] = mb[(byte_addr + k) % NB];
        return w;
    endfunction

    task automatic preload(input int w, input logic [31:0] d);
        @(negedge clk);
        ld_en   = 1'b1;
        ld_addr = AW'(w);
        ld_data = d;
        for (int k = 0; k < 4; k++) mb[4*w + k] = d[8*k +: 8];
        @(negedge clk);
        ld_en = 1'b0;
    endtask

    task automatic spi_bits(input logic [31:0] val, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            @(negedge clk);
            spi_select = 1'b0;
            spi_mosi   = val[i];
        end
    endtask

    task automatic spi_end();
        @(negedge clk);
        spi_select = 1'b1;
        spi_mosi   = 1'b0;
        @(negedge clk);
    endtask

    task automatic start_txn(input logic [7:0] cmd, input logic [23:0] addr);
        spi_bits({24'h0, cmd}, 8);
        spi_bits({8'h0, addr}, 24);
    endtask

    task automatic read_byte(output logic [7:0] b);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            b[i] = spi_miso;
        end
    endtask

    task automatic write_byte(input logic [7:0] b);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            spi_mosi = b[i];
        end
    endtask

    task automatic read_word(input logic [23:0] addr, output logic [31:0] w);
        logic [7:0] b;
        start_txn(8'h03, addr);
        for (int k = 0; k < 4; k++) begin
            read_byte(b);
            w[8*k +: 8] = b;
        end
        spi_end();
    endtask

    initial begin
        logic [31:0] w;
        logic [31:0] rx;
        logic [7:0]  b;
        logic        ign_or;
        logic [23:0] a;
        int          n;
        int          op;

        vecs[0] = '{24'h000000, 32'h00000013};
        vecs[1] = '{24'h000004, 32'hDEADBEEF};
        vecs[2] = '{24'h000002, 32'hBEEF0000};
        vecs[3] = '{24'h000FFF, 32'h000013AA};
        vecs[4] = '{24'hFFF004, 32'hDEADBEEF};
        vecs[5] = '{24'h000007, 32'h543210DE};

        rstn       = 1'b0;
        spi_select = 1'b1;
        spi_mosi   = 1'b0;
        ld_en      = 1'b0;
        ld_addr    = '0;
        ld_data    = '0;
        #12;
        check("reset_miso", {31'h0, spi_miso}, 32'h0);
        check("reset_busy", {31'h0, busy}, 32'h0);
        @(negedge clk);
        rstn = 1'b1;

        for (int i = 0; i < DEPTH; i++) preload(i, $urandom());
        preload(0, 32'h00000013);
        preload(1, 32'hDEADBEEF);
        preload(2, 32'h76543210);
        preload(DEPTH - 1, 32'hAA000000);

        // Table-driven reads, expectations worked out by hand.
        foreach (vecs[i]) begin
            read_word(vecs[i].addr, w);
            check($sformatf("vec_rd[%0d]", i), w, vecs[i].exp);
        end

        // 64-clock stream into a right-shifting receiver.
        start_txn(8'h03, 24'h000000);
        rx = '0;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            rx = {spi_miso, rx[31:1]};
            if (i == 31) check("stream_w0", rx, 32'h00000013);
        end
        check("stream_w1", rx, 32'hDEADBEEF);
        spi_end();

        // Write four bytes then read them back.
        start_txn(8'h02, 24'h000004);
        write_byte(8'h11); write_byte(8'h22); write_byte(8'h33); write_byte(8'h44);
        spi_end();
        for (int k = 0; k < 4; k++) mb[4 + k] = 8'(8'h11 * (k + 1));
        read_word(24'h000004, w);
        check("write_rb", w, 32'h44332211);

        // Partial write byte is dropped on deselect.
        start_txn(8'h02, 24'h000008);
        spi_bits(32'h1F, 5);
        spi_end();
        check("partial_busy", {31'h0, busy}, 32'h0);
        read_word(24'h000008, w);
        check("partial_rb", w, 32'h76543210);

        // Abort at the third command bit.
        spi_bits(32'h0, 3);
        check("abort_busy_pre", {31'h0, busy}, 32'h1);
        @(negedge clk);
        spi_select = 1'b1;
        @(negedge clk);
        check("abort_busy_post", {31'h0, busy}, 32'h0);
        read_word(24'h000000, w);
        check("abort_next_rd", w, 32'h00000013);

        // Unknown command: miso stays low, memory untouched.
        spi_bits(32'h0B, 8);
        ign_or = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            ign_or   = ign_or | spi_miso;
            spi_mosi = 1'($urandom());
        end
        check("ignore_miso", {31'h0, ign_or}, 32'h0);
        check("ignore_busy", {31'h0, busy}, 32'h1);
        spi_end();
        read_word(24'h000004, w);
        check("ignore_mem", w, model_word(4));

        // Preload collides with the SPI byte write to the same word.
        start_txn(8'h02, 24'h000010);
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            spi_mosi = 1'b1;
        end
        @(negedge clk);
        spi_mosi = 1'b0;
        ld_en    = 1'b1;
        ld_addr  = AW'(4);
        ld_data  = 32'hCAFEF00D;
        @(negedge clk);
        ld_en      = 1'b0;
        spi_select = 1'b1;
        @(negedge clk);
        for (int k = 0; k < 4; k++) mb[16 + k] = 8'(32'hCAFEF00D >> (8 * k));
        read_word(24'h000010, w);
        check("collide_rb", w, 32'hCAFEF00D);

        // Asynchronous reset in the middle of a read.
        start_txn(8'h03, 24'h000000);
        @(negedge clk);
        check("mid_rd_bit0", {31'h0, spi_miso}, 32'h1);
        #2;
        rstn = 1'b0;
        #1;
        check("async_rst_miso", {31'h0, spi_miso}, 32'h0);
        check("async_rst_busy", {31'h0, busy}, 32'h0);
        @(negedge clk);
        spi_select = 1'b1;
        @(negedge clk);
        rstn = 1'b1;
        read_word(24'h000000, w);
        check("rst_keep_w0", w, model_word(0));
        read_word(24'h000004, w);
        check("rst_keep_w1", w, model_word(4));

        // Random traffic against the byte model.
        for (int t = 0; t < 30; t++) begin
            op = $urandom_range(0, 2);
            a  = 24'($urandom());
            if ($urandom_range(0, 3) == 0) a[11:0] = 12'hFFC + 12'($urandom_range(0, 3));
            n  = $urandom_range(1, 6);
            if (op == 1) begin
                start_txn(8'h02, a);
                for (int k = 0; k < n; k++) begin
                    b = 8'($urandom());
                    write_byte(b);
                    mb[(int'(a[11:0]) + k) % NB] = b;
                end
                spi_end();
            end else if (op == 2) begin
                start_txn(8'h02, a);
                spi_bits($urandom(), $urandom_range(1, 7));
                spi_end();
            end
            start_txn(8'h03, a);
            for (int k = 0; k < n; k++) begin
                read_byte(b);
                check($sformatf("rand_rd[%0d.%0d]", t, k), {24'h0, b},
                      {24'h0, mb[(int'(a[11:0]) + k) % NB]});
            end
            spi_end();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
